// File: rtl/fifo_sync_asym_ctl.sv
// fifo_sync_asym_ctl: single-clock asymmetric-width FIFO with watermarks, sticky error flags and flush
module fifo_sync_asym_ctl #(
  parameter int WR_W   = 18,
  parameter int RD_W   = 9,
  parameter int ADDR_W = 11,
  parameter int UPAF   = 16,
  parameter int UPAE   = 16
) (
  input  logic              CLK_i,
  input  logic              RST_i,
  input  logic              FLUSH_ni,
  input  logic              WEN_i,
  input  logic [WR_W-1:0]   WDATA_i,
  input  logic              REN_i,
  output logic [RD_W-1:0]   RDATA_o,
  output logic              RVALID_o,
  output logic [ADDR_W:0]   COUNT_o,
  output logic              FULL_o,
  output logic              FMO_o,
  output logic              FWM_o,
  output logic              OVERRUN_o,
  output logic              EMPTY_o,
  output logic              EPO_o,
  output logic              EWM_o,
  output logic              UNDERRUN_o
);
  localparam int N     = WR_W < RD_W ? WR_W : RD_W;
  localparam int WS    = WR_W / N;
  localparam int RS    = RD_W / N;
  localparam int RATIO = WS > RS ? WS : RS;
  localparam int CAP   = 2 ** ADDR_W;
  localparam int CW    = ADDR_W + 1;
  if (!(RATIO == 1 || RATIO == 2 || RATIO == 4) || (WR_W % N) != 0 || (RD_W % N) != 0) begin : g_ratio_chk
    $error("fifo_sync_asym_ctl: width ratio must be 1, 2 or 4");
  end
  logic [N-1:0]      mem_q [CAP];
  logic [ADDR_W-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              wr_acc, rd_acc;
  logic [RD_W-1:0]   rd_word;
  int                free_d;
  assign COUNT_o = cnt_q;
  // Accept decisions from pre-edge flags; flush overrides both requests
  always_comb begin
    wr_acc  = FLUSH_ni & WEN_i & ~FULL_o;
    rd_acc  = FLUSH_ni & REN_i & ~EMPTY_o;
    wp_d    = !FLUSH_ni ? '0 : wr_acc ? wp_q + ADDR_W'(WS) : wp_q;
    rp_d    = !FLUSH_ni ? '0 : rd_acc ? rp_q + ADDR_W'(RS) : rp_q;
    cnt_d   = !FLUSH_ni ? '0 : cnt_q + (wr_acc ? CW'(WS) : '0) - (rd_acc ? CW'(RS) : '0);
    free_d  = CAP - int'(cnt_d);
    rd_word = '0;
    for (int k = 0; k < RS; k++) rd_word[k*N +: N] = mem_q[rp_q + ADDR_W'(k)];
  end
  // Storage commits all write lanes at once; an op coinciding with reset is dropped
  always_ff @(posedge CLK_i) begin
    if (wr_acc & ~RST_i)
      for (int k = 0; k < WS; k++) mem_q[wp_q + ADDR_W'(k)] <= WDATA_i[k*N +: N];
  end
  // Pointers, count, read register and flags; flags derive from the post-edge count
  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      wp_q       <= '0;
      rp_q       <= '0;
      cnt_q      <= '0;
      RDATA_o    <= '0;
      RVALID_o   <= 1'b0;
      OVERRUN_o  <= 1'b0;
      UNDERRUN_o <= 1'b0;
      FULL_o     <= CAP < WS;
      FMO_o      <= CAP < 2 * WS;
      FWM_o      <= CAP <= UPAF;
      EMPTY_o    <= 1'b1;
      EPO_o      <= 1'b1;
      EWM_o      <= 1'b1;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      cnt_q      <= cnt_d;
      RDATA_o    <= !FLUSH_ni ? '0 : rd_acc ? rd_word : RDATA_o;
      RVALID_o   <= rd_acc;
      OVERRUN_o  <= FLUSH_ni & (OVERRUN_o | (WEN_i & FULL_o));
      UNDERRUN_o <= FLUSH_ni & (UNDERRUN_o | (REN_i & EMPTY_o));
      FULL_o     <= free_d < WS;
      FMO_o      <= free_d < 2 * WS;
      FWM_o      <= free_d <= UPAF;
      EMPTY_o    <= int'(cnt_d) < RS;
      EPO_o      <= int'(cnt_d) < 2 * RS;
      EWM_o      <= int'(cnt_d) <= UPAE;
    end
  end
endmodule

// File: tb/tb_fifo_sync_asym_ctl.sv
// tb_fifo_sync_asym_ctl: queue-model bench for the asymmetric FIFO controller
module tb_fifo_sync_asym_ctl;
  localparam int WR_W = 18, RD_W = 9, N = 9, WS = 2, RS = 1, CAP = 2048, UPAF = 16, UPAE = 16;
  logic clk = 0, rst = 1, flush_n = 1, wen = 0, ren = 0;
  logic [WR_W-1:0] wdata = '0;
  logic [RD_W-1:0] rdata;
  logic [11:0] count;
  logic rvalid, full, fmo, fwm, ovr, empty, epo, ewm, und;
  logic b_wen = 0, b_ren = 0, b_fl_n = 1;
  logic [8:0] b_wdata = '0;
  logic [35:0] b_rdata;
  logic [4:0] b_count;
  logic b_rvalid, b_full, b_fmo, b_fwm, b_ovr, b_empty, b_epo, b_ewm, b_und;
  logic [N-1:0] mq[$];
  logic [RD_W-1:0] m_rdata = '0;
  logic m_rvalid = 0, m_ovr = 0, m_und = 0, chk_en = 0;
  int n_chk = 0, n_fail = 0, wr_cnt = 0;
  always #5 clk = ~clk;
  fifo_sync_asym_ctl #(.WR_W(WR_W), .RD_W(RD_W), .ADDR_W(11), .UPAF(UPAF), .UPAE(UPAE)) dut (
    .CLK_i(clk), .RST_i(rst), .FLUSH_ni(flush_n), .WEN_i(wen), .WDATA_i(wdata), .REN_i(ren),
    .RDATA_o(rdata), .RVALID_o(rvalid), .COUNT_o(count), .FULL_o(full), .FMO_o(fmo), .FWM_o(fwm),
    .OVERRUN_o(ovr), .EMPTY_o(empty), .EPO_o(epo), .EWM_o(ewm), .UNDERRUN_o(und));
  fifo_sync_asym_ctl #(.WR_W(9), .RD_W(36), .ADDR_W(4), .UPAF(2), .UPAE(2)) dut_b (
    .CLK_i(clk), .RST_i(rst), .FLUSH_ni(b_fl_n), .WEN_i(b_wen), .WDATA_i(b_wdata), .REN_i(b_ren),
    .RDATA_o(b_rdata), .RVALID_o(b_rvalid), .COUNT_o(b_count), .FULL_o(b_full), .FMO_o(b_fmo), .FWM_o(b_fwm),
    .OVERRUN_o(b_ovr), .EMPTY_o(b_empty), .EPO_o(b_epo), .EWM_o(b_ewm), .UNDERRUN_o(b_und));
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_clear();
    mq.delete();
    m_rdata = '0;
    m_rvalid = 0;
    m_ovr = 0;
    m_und = 0;
  endtask
  task automatic model_upd();
    int c = mq.size();
    bit m_full = (CAP - c) < WS;
    bit m_empty = c < RS;
    if (!flush_n) model_clear();
    else begin
      if (wen && m_full) m_ovr = 1;
      if (ren && m_empty) m_und = 1;
      m_rvalid = ren && !m_empty;
      if (m_rvalid) for (int k = 0; k < RS; k++) m_rdata[k*N +: N] = mq.pop_front();
      if (wen && !m_full) begin
        for (int k = 0; k < WS; k++) mq.push_back(wdata[k*N +: N]);
        wr_cnt++;
      end
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    model_upd();
  endtask
  task automatic step(input logic w, input logic [WR_W-1:0] d, input logic r, input logic fl);
    @(negedge clk);
    wen = w; wdata = d; ren = r; flush_n = ~fl; b_wen = 0; b_ren = 0;
    tick();
  endtask
  task automatic step_b(input logic w, input logic [8:0] d, input logic r);
    @(negedge clk);
    wen = 0; ren = 0; flush_n = 1; b_wen = w; b_wdata = d; b_ren = r;
    tick();
  endtask
  task automatic wr_n(input int n);
    for (int i = 0; i < n; i++) step(1, WR_W'($urandom), 0, 0);
  endtask
  task automatic rd_n(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 1, 0);
  endtask
  task automatic do_rst();
    #1 rst = 1;
    #1 model_clear();
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_fwm", fwm, 0);
    chk("arst_ovr", ovr, 0);
    chk("arst_und", und, 0);
    chk("arst_rdata", rdata, 0);
    #1 rst = 0;
  endtask
  // Every cycle: all main-instance outputs against the queue model
  always @(negedge clk) begin
    int c;
    if (chk_en && !rst) begin
      c = mq.size();
      chk("count", count, c);
      chk("rvalid", rvalid, m_rvalid);
      chk("rdata", rdata, m_rdata);
      chk("overrun", ovr, m_ovr);
      chk("underrun", und, m_und);
      chk("full", full, (CAP - c) < WS);
      chk("fmo", fmo, (CAP - c) < 2 * WS);
      chk("fwm", fwm, (CAP - c) <= UPAF);
      chk("empty", empty, c < RS);
      chk("epo", epo, c < 2 * RS);
      chk("ewm", ewm, c <= UPAE);
    end
  end
  initial begin
    int base, pw, pr;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    model_clear();
    chk_en = 1;
    chk("rst_empty", empty, 1);
    chk("rst_epo", epo, 1);
    chk("rst_ewm", ewm, 1);
    chk("rst_full", full, 0);
    // write one wide word, read back both lanes
    step(1, 18'h2_0155, 0, 0);
    chk("t1_cnt2", count, 2);
    step(0, '0, 1, 0);
    chk("t1_rd0", rdata, 9'h155);
    chk("t1_rv0", rvalid, 1);
    chk("t1_cnt1", count, 1);
    step(0, '0, 1, 0);
    chk("t1_rd1", rdata, 9'h100);
    chk("t1_rv1", rvalid, 1);
    chk("t1_cnt0", count, 0);
    chk("t1_empty", empty, 1);
    step(0, '0, 0, 0);
    chk("t1_rv_low", rvalid, 0);
    chk("t1_hold", rdata, 9'h100);
    // fill to full, overrun, then two reads to leave full
    wr_n(1022);
    chk("t2_fmo_1022", fmo, 0);
    wr_n(1);
    chk("t2_fmo_1023", fmo, 1);
    chk("t2_full_1023", full, 0);
    wr_n(1);
    chk("t2_full", full, 1);
    chk("t2_cnt", count, 2048);
    wr_n(1);
    chk("t2_ovr", ovr, 1);
    chk("t2_cnt_ovr", count, 2048);
    step(0, '0, 0, 0);
    chk("t2_ovr_sticky", ovr, 1);
    rd_n(1);
    chk("t2_full_r1", full, 1);
    chk("t2_cnt_r1", count, 2047);
    rd_n(1);
    chk("t2_full_r2", full, 0);
    // simultaneous read and write while full: read only
    wr_n(1);
    chk("t5_full_again", count, 2048);
    step(1, WR_W'($urandom), 1, 0);
    chk("t5_full_rw", count, 2047);
    // drain to 1000 with overrun still set, then flush with a write pending
    rd_n(1047);
    chk("t6_cnt1000", count, 1000);
    chk("t6_ovr_set", ovr, 1);
    step(1, WR_W'($urandom), 0, 1);
    chk("t6_flush_cnt", count, 0);
    chk("t6_flush_empty", empty, 1);
    chk("t6_flush_ovr", ovr, 0);
    // simultaneous read and write at count 6
    wr_n(3);
    step(1, WR_W'($urandom), 1, 0);
    chk("t5_rw_cnt7", count, 7);
    rd_n(8);
    chk("t6_und", und, 1);
    wr_n(500);
    chk("t6_cnt1000b", count, 1000);
    do_rst();
    // read on empty after reset
    step(0, '0, 1, 0);
    chk("t3_und", und, 1);
    chk("t3_rv", rvalid, 0);
    chk("t3_rdata", rdata, 0);
    chk("t3_cnt", count, 0);
    // watermarks
    wr_n(8);
    chk("t4_ewm16", ewm, 1);
    wr_n(1);
    chk("t4_ewm18", ewm, 0);
    wr_n(1006);
    chk("t4_cnt2030", count, 2030);
    chk("t4_fwm2030", fwm, 0);
    wr_n(1);
    chk("t4_fwm2032", fwm, 1);
    // random-rate stream with wrap-around
    step(0, '0, 0, 1);
    base = wr_cnt;
    pw = 50; pr = 50;
    for (int i = 0; i < 40000 && wr_cnt - base < 5000; i++) begin
      if (i % 500 == 0) begin
        pw = $urandom_range(20, 90);
        pr = $urandom_range(20, 90);
      end
      step($urandom_range(0, 99) < pw, WR_W'($urandom), $urandom_range(0, 99) < pr, 0);
    end
    chk("stream_writes_done", (wr_cnt - base) >= 5000, 1);
    for (int i = 0; i < 3000 && mq.size() > 0; i++) step(0, '0, 1, 0);
    chk("stream_drained", empty, 1);
    // narrow-write, wide-read instance
    for (int i = 0; i < 3; i++) begin
      step_b(1, 9'(17 * (i + 1)), 0);
      chk("b_empty_partial", b_empty, 1);
    end
    step_b(1, 9'h1F4, 0);
    chk("b_empty_4", b_empty, 0);
    chk("b_cnt_4", b_count, 4);
    step_b(0, '0, 1);
    chk("b_rdata", b_rdata, {9'h1F4, 9'd51, 9'd34, 9'd17});
    chk("b_rvalid", b_rvalid, 1);
    chk("b_cnt_0", b_count, 0);
    chk("b_empty_0", b_empty, 1);
    step(0, '0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
